// File: rtl/imm_ext_scheduler_pkg.sv
// Shared definitions for the immediate-extension scheduler.
// Format codes, FSM state encoding and the default result width.
// Optional feature macro used elsewhere: IMM_EXT_ZIMM_EN (FMT_Z = CSR uimm zero-extension).
package imm_pkg;

    localparam int XLEN_DEF = 32;
    localparam int FMT_W    = 3;

    localparam logic [FMT_W-1:0] FMT_I = 3'd0;
    localparam logic [FMT_W-1:0] FMT_S = 3'd1;
    localparam logic [FMT_W-1:0] FMT_B = 3'd2;
    localparam logic [FMT_W-1:0] FMT_U = 3'd3;
    localparam logic [FMT_W-1:0] FMT_J = 3'd4;
    localparam logic [FMT_W-1:0] FMT_Z = 3'd5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/imm_ext_scheduler_if.sv
// Handshake bundle between the two requesters, the scheduler and the consumer.
// The scheduler uses the slave modport; requesters/consumer drive the master side.
interface imm_ext_scheduler_if
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW_W = 21
);
    logic             REQ0_VALID;
    logic             REQ0_READY;
    logic [FMT_W-1:0] REQ0_FMT;
    logic [RAW_W-1:0] REQ0_RAW;

    logic             REQ1_VALID;
    logic             REQ1_READY;
    logic [FMT_W-1:0] REQ1_FMT;
    logic [RAW_W-1:0] REQ1_RAW;

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT_DATA;
    logic             OUT_ID;
    logic             OUT_ERR;

    modport master (
        output REQ0_VALID, REQ0_FMT, REQ0_RAW,
        output REQ1_VALID, REQ1_FMT, REQ1_RAW,
        output OUT_READY,
        input  REQ0_READY, REQ1_READY,
        input  OUT_VALID, OUT_DATA, OUT_ID, OUT_ERR
    );

    modport slave (
        input  REQ0_VALID, REQ0_FMT, REQ0_RAW,
        input  REQ1_VALID, REQ1_FMT, REQ1_RAW,
        input  OUT_READY,
        output REQ0_READY, REQ1_READY,
        output OUT_VALID, OUT_DATA, OUT_ID, OUT_ERR
    );
endinterface

// File: rtl/imm_ext_scheduler_core.sv
// Combinational RISC-V immediate formatter: FMT + RAW -> DATA + ERR.
// IMM_EXT_ZIMM_EN enables FMT_Z (zero-extended 5-bit CSR uimm); otherwise FMT_Z is an error code.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW_W = 21
) (
    input  logic [FMT_W-1:0] i_fmt,
    input  logic [RAW_W-1:0] i_raw,
    output logic [XLEN-1:0]  o_data,
    output logic             o_err
);

    // Format the raw field; unsupported codes return zero with ERR set
    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: o_data = {{(XLEN-12){i_raw[11]}}, i_raw[11:0]};
            FMT_B:        o_data = {{(XLEN-13){i_raw[12]}}, i_raw[12:1], 1'b0};
            FMT_U:        o_data = {i_raw[19:0], {(XLEN-20){1'b0}}};
            FMT_J:        o_data = {{(XLEN-21){i_raw[20]}}, i_raw[20:1], 1'b0};
`ifdef IMM_EXT_ZIMM_EN
            FMT_Z:        o_data = {{(XLEN-5){1'b0}}, i_raw[4:0]};
`endif
            default:      o_err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_scheduler.sv
// Two-requester immediate-extension scheduler: round-robin (or fixed) arbiter,
// one shared imm_ext_core, and a one-deep registered valid/ready output stage.
// Optional build macro: IMM_EXT_ZIMM_EN (handled inside imm_ext_core).
module imm_ext_scheduler
    import imm_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RAW_W      = 21,
    parameter int PRIO_FIXED = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    imm_ext_scheduler_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ptr;        // 1: req1 preferred on contention
    logic [XLEN-1:0]   r_data;
    logic              r_id;
    logic              r_err;

    logic              w_fixed;
    logic              w_can_accept;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic [FMT_W-1:0]  w_fmt;
    logic [RAW_W-1:0]  w_raw;
    logic [XLEN-1:0]   w_data;
    logic              w_err;

    assign w_fixed = (PRIO_FIXED != 0);

    // Arbitration: nothing is granted while in reset or while a held result cannot leave
    always_comb begin
        w_can_accept = ((r_state == ST_EMPTY) | bus.OUT_READY) & ~RESET;
        w_gnt0 = w_can_accept & bus.REQ0_VALID &
                 (~bus.REQ1_VALID | w_fixed | ~r_ptr);
        w_gnt1 = w_can_accept & bus.REQ1_VALID &
                 (~bus.REQ0_VALID | (~w_fixed & r_ptr));
        w_grant = w_gnt0 | w_gnt1;
    end

    assign bus.REQ0_READY = w_gnt0;
    assign bus.REQ1_READY = w_gnt1;

    // Route the winning requester into the shared formatter
    always_comb begin
        w_fmt = bus.REQ0_FMT;
        w_raw = bus.REQ0_RAW;
        if (w_gnt1) begin
            w_fmt = bus.REQ1_FMT;
            w_raw = bus.REQ1_RAW;
        end
    end

    imm_ext_core #(
        .XLEN  (XLEN),
        .RAW_W (RAW_W)
    ) u_core (
        .i_fmt  (w_fmt),
        .i_raw  (w_raw),
        .o_data (w_data),
        .o_err  (w_err)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: a grant always fills; a consume without grant drains
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (bus.OUT_READY && !w_grant) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.OUT_VALID = (r_state == ST_FULL);
    end

    // Round-robin pointer: after a grant, prefer the other requester next time
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        r_ptr <= 1'b0;
        else if (w_grant) r_ptr <= w_gnt0;
    end

    // Result register: loads on grant, otherwise holds (stable while stalled)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data <= '0;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_grant) begin
            r_data <= w_data;
            r_id   <= w_gnt1;
            r_err  <= w_err;
        end
    end

    assign bus.OUT_DATA = r_data;
    assign bus.OUT_ID   = r_id;
    assign bus.OUT_ERR  = r_err;

endmodule

// File: doc/imm_ext_scheduler.md
Name: imm_ext_scheduler

Overview:
- Shares one immediate sign/zero-extension datapath between two requesters: req0 is ID-stage decode, req1 is the branch-target unit.
- Arbitrates between them round-robin, formats the raw immediate field per RISC-V format, and registers a 32-bit result.
- Output uses a valid/ready handshake and is tagged with the requester ID.
- Sits between decode/branch logic and the ID/EX pipeline register.

Parameters:
- XLEN, 32, result width.
- RAW_W, 21, width of the raw immediate field (widest case is the J-type immediate).
- PRIO_FIXED, 0. When 1, req0 always wins arbitration; when 0, round-robin.

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ0_VALID  input  1  req0 presents a request
- REQ0_READY  output  1  req0 request accepted this cycle
- REQ0_FMT  input  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J
- REQ0_RAW  input  RAW_W  raw immediate bits, already gathered, LSB-aligned
- REQ1_VALID / REQ1_READY / REQ1_FMT / REQ1_RAW  as req0
- OUT_VALID  output  1  OUT_DATA holds a result
- OUT_READY  input  1  consumer takes the result
- OUT_DATA  output  XLEN  extended immediate
- OUT_ID  output  1  requester that owns OUT_DATA
- OUT_ERR  output  1  unsupported FMT (OUT_DATA=0)

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high, RESET.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_ID=0, OUT_ERR=0, round-robin pointer prefers req0, FSM=EMPTY.
- Reset mid-operation discards any held result; no request is accepted during RESET.
- FSM states:
  - EMPTY: no result held.
  - FULL: result held.
  - EMPTY->FULL on a grant.
  - FULL->EMPTY on OUT_READY with no grant.
  - FULL->FULL on OUT_READY with a grant (back-to-back, one result per cycle).
  - FULL with OUT_READY=0 holds OUT_DATA/OUT_ID/OUT_ERR stable.
- Accept condition: can_accept = (state==EMPTY) | OUT_READY.
- Arbitration:
  - Grant only if can_accept.
  - One valid request: it wins.
  - Both valid: winner is the requester not granted last time (round-robin), or req0 when PRIO_FIXED=1.
  - REQx_READY=1 only for the winner. It is combinational from the VALIDs, the pointer and OUT_READY.
  - The pointer updates only on a grant.
- Requester rule: FMT/RAW must stay stable while VALID=1 and READY=0. A requester may drop VALID without a grant.
- Latency: granted request appears on OUT_* at the next rising CLK edge (1 cycle).
- Extension rules (sx = sign-extend to XLEN):
  - I and S: sx(RAW[11:0]).
  - B: sx({RAW[12:1],1'b0}); RAW[0] is ignored.
  - U: {RAW[19:0],12'b0}.
  - J: sx({RAW[20:1],1'b0}).
  - FMT 5..7: OUT_DATA=0, OUT_ERR=1, OUT_ID still set.
- Simultaneous events:
  - Grant plus OUT_READY in FULL: the old result is consumed and the new one loaded in the same edge.
  - OUT_READY in EMPTY: ignored.

Optional Feature:
- Macro: IMM_EXT_ZIMM_EN.
- Defined: FMT=5 is valid and selects zero extension, OUT_DATA = {27'b0, RAW[4:0]} (CSR uimm), OUT_ERR=0.
- Undefined: FMT=5 is treated like 6/7 (OUT_DATA=0, OUT_ERR=1).

Decomposition:
- Shared package imm_pkg:
  - Format-code constants FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z.
  - FSM state encoding ST_EMPTY, ST_FULL.
  - XLEN default.
- Sub-module imm_ext_core: purely combinational FMT+RAW -> DATA+ERR. It is instantiated once and driven by the granted requester's mux output. The scheduler holds the FSM, arbiter and output register.

Test Plan:
- Single req0, FMT=I, RAW=0x00FFF, OUT_READY=1: REQ0_READY=1 same cycle; next cycle OUT_VALID=1, OUT_DATA=0xFFFFFFFF, OUT_ID=0.
- req1 alone, FMT=B then FMT=U:
  - B, RAW=0x01001 -> OUT_DATA=0xFFFFF000.
  - U, RAW=0x12345 -> 0x12345000.
  - Both with OUT_ID=1.
- Both valid for 4 cycles, OUT_READY=1, PRIO_FIXED=0: grants alternate 0,1,0,1; PRIO_FIXED=1 gives 0,0,0,0.
- OUT_READY=0 after FMT=J, RAW=0x100000:
  - OUT_DATA=0xFFF00000 held for 3 cycles.
  - REQx_READY=0 throughout.
  - Raising OUT_READY with req0 valid swaps in the new result the same edge.
- FMT=6 -> OUT_ERR=1, OUT_DATA=0. FMT=5, RAW=0x1F -> 0x0000001F with IMM_EXT_ZIMM_EN, OUT_ERR=1 without.
- RESET asserted asynchronously while FULL and stalled: OUT_VALID=0 immediately, pointer back to req0, and the first post-reset contention grants req0.
